ps2_key_tracker: RTL
====================

// Module: ps2_key_tracker
// PURPOSE
//  Consumes scan-code bytes from the ps2_keyboard receive FIFO through its ready/nextdata_n handshake.
//  Decodes set-2 make, break (F0) and extended (E0) prefixes, and filters typematic repeats.
//  Tracks up to KEY_SLOTS simultaneously held keys and counts distinct key presses.
//  Sits between ps2_keyboard and the display/ASCII path (tranAscii, bcd7seg) in SimTop.
// PARAMETERS
//  KEY_SLOTS     4  number of simultaneously held keys tracked (1..8)
//  CNT_W         8  width of press_count; the counter wraps modulo 2**CNT_W
//  REPORT_REPEAT 0  1: typematic repeats raise key_valid with key_repeat=1; 0: repeats are silent
// PORTS
//  clock        in   1        system clock
//  reset        in   1        asynchronous, active-high reset
//  fifo_ready   in   1        ps2_keyboard ready: FIFO non-empty
//  fifo_data    in   8        ps2_keyboard data: head of FIFO
//  fifo_ovf     in   1        ps2_keyboard overflow
//  nextdata_n   out  1        active-low pop strobe to ps2_keyboard
//  key_valid    out  1        one-cycle pulse: key event on key_* outputs
//  key_code     out  8        scan code of the event (prefixes stripped)
//  key_ext      out  1        event carried an E0 prefix
//  key_make     out  1        1 = press/repeat, 0 = release
//  key_repeat   out  1        event is a typematic repeat of an already held key
//  last_code    out  8        code of the most recent new make; held until the next one
//  any_held     out  1        at least one slot valid
//  held_count   out  4        number of valid slots
//  press_count  out  CNT_W    count of new makes (repeats excluded)
//  err_sticky   out  2        [0] slot table full on a make; [1] fifo_ovf seen; cleared only by reset
// BEHAVIOUR
//  Reset (async): nextdata_n=1, all key_* outputs 0, last_code=0, press_count=0, slots invalid,
//   err_sticky=0, prefix FSM in P_IDLE, skip counter 0.
//  Pop handshake: when fifo_ready=1 and no pop is pending, the block latches fifo_data and drives
//   nextdata_n=0 for exactly one cycle. The next cycle is a holdoff cycle with no pop, because the
//   FIFO pointer updates one cycle late. Peak rate: one byte every 2 cycles.
//  Decode happens the cycle after the latch; key_valid pulses 1 cycle later still. fifo_ready-to-key_valid latency is 2 cycles.
//  Prefix FSM states: P_IDLE, P_E0, P_F0, P_E0F0.
//   P_IDLE: E0 -> P_E0; F0 -> P_F0.
//   P_E0:   F0 -> P_E0F0.
//   Any prefix state: E0 restarts to P_E0. F0 in P_F0 stays P_F0; F0 in P_E0F0 stays P_E0F0.
//   Any other byte: event with ext=(state in {P_E0, P_E0F0}) and make=(state in {P_IDLE, P_E0}); FSM -> P_IDLE.
//  Ignored bytes (P_IDLE only; no event, no state change): 00, AA, EE, FA, FC, FD, FE, FF.
//  Pause key: E1 in P_IDLE emits a single make event with code=E1, ext=0.
//   The following 7 bytes are consumed silently (3-bit skip counter); Pause never enters the slot table.
//  Make of a code {ext,code} already in a slot: this is a repeat. press_count and slots are unchanged;
//   key_valid pulses (key_repeat=1) only if REPORT_REPEAT=1.
//  Make of a new code:
//   - Stored in the lowest-index free slot; press_count+1 (wraps); last_code updated.
//   - If no slot is free: err_sticky[0]=1 and the key is not stored, but press_count, last_code and key_valid still update.
//  Break: the matching slot is invalidated and key_valid pulses with make=0.
//   A break with no matching slot still emits the event and changes nothing else.
//  held_count and any_held are registered and reflect the slot state after the event, in the same cycle as key_valid.
//  err_sticky[1] sets on any cycle with fifo_ovf=1.
//  Reset mid-sequence: everything is cleared immediately. A byte the FIFO already popped is lost;
//   a byte latched but not yet decoded is discarded.
// STRUCTURE
//  Shared package ps2_pkg:
//   - prefix-state localparams
//   - scan-code constants E0, F0, E1 and the ignore list
//   - typedef key_id_t = {ext, code[7:0]} (9 bits)
//  Sub-module ps2_key_slots: KEY_SLOTS-entry CAM of key_id_t with lookup-hit, insert-first-free,
//   delete-match and popcount outputs.
//  The top level holds the pop handshake, the prefix FSM, the skip counter and the counters.
// TESTING
//  1C; F0 1C -> make 1C ext=0, then break 1C; press_count=1; held_count 1 then 0; last_code=1C.
//  E0 75; E0 F0 75 -> make 75 ext=1, then break 75 ext=1; FSM ends in P_IDLE.
//  1B 1B 1B F0 1B, REPORT_REPEAT=0 -> one make, one break; press_count+1.
//   Same stimulus with REPORT_REPEAT=1 -> 2 extra events with key_repeat=1.
//  Makes 1C 1B 23 2B 34 (KEY_SLOTS=4) -> err_sticky[0]=1; held_count=4; press_count=5; last_code=34.
//  E1 14 77 E1 F0 14 F0 77 then 1C -> exactly 2 events (E1 make, 1C make); held_count=1.
//  press_count at 2**CNT_W-1, new make -> 0. Assert reset between the E0 byte and the code byte
//   -> all outputs 0 at once; a following 75 decodes as non-extended.
//  Every test: nextdata_n is never low on two consecutive cycles, and never low while fifo_ready=0.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared scan-code constants, prefix states and key identifier type for the
// PS/2 key tracking path.
package ps2_pkg;

  typedef enum logic [1:0] {
    P_IDLE = 2'd0,
    P_E0   = 2'd1,
    P_F0   = 2'd2,
    P_E0F0 = 2'd3
  } prefix_state_e;

  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_F0 = 8'hF0;
  localparam logic [7:0] SC_E1 = 8'hE1;

  // Bytes that follow E1 in the Pause sequence and are swallowed silently.
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef struct packed {
    logic       ext;
    logic [7:0] code;
  } key_id_t;

  // Controller/keyboard housekeeping bytes that never describe a key.
  function automatic logic is_ignored(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: is_ignored = 1'b1;
      default:                                                is_ignored = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_key_slots.sv
// Small CAM of currently held keys: lookup hit, insert into the lowest free
// slot, delete on match, and a popcount of valid slots.
module ps2_key_slots
  import ps2_pkg::*;
#(
  parameter int KEY_SLOTS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  key_id_t    key_i,
  input  logic       insert_i,
  input  logic       delete_i,
  output logic       hit_o,
  output logic       full_o,
  output logic [3:0] held_count_o
);

  key_id_t              slot_key_q [KEY_SLOTS];
  logic [KEY_SLOTS-1:0] slot_vld_q;
  logic [KEY_SLOTS-1:0] slot_vld_d;
  logic [KEY_SLOTS-1:0] hit_vec;
  logic [KEY_SLOTS-1:0] free_oh;
  logic                 taken;

  always_comb begin
    hit_vec = '0;
    free_oh = '0;
    taken   = 1'b0;
    for (int i = 0; i < KEY_SLOTS; i++) begin
      hit_vec[i] = slot_vld_q[i] && (slot_key_q[i] == key_i);
      if (!slot_vld_q[i] && !taken) begin
        free_oh[i] = 1'b1;
        taken      = 1'b1;
      end
    end
  end

  assign hit_o  = |hit_vec;
  assign full_o = &slot_vld_q;

  // A key already present is never inserted twice; a full table drops the insert.
  always_comb begin
    slot_vld_d = slot_vld_q;
    if (insert_i && !hit_o) slot_vld_d = slot_vld_d | free_oh;
    if (delete_i)           slot_vld_d = slot_vld_d & ~hit_vec;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot_vld_q <= '0;
      for (int i = 0; i < KEY_SLOTS; i++) slot_key_q[i] <= '0;
    end else begin
      slot_vld_q <= slot_vld_d;
      for (int i = 0; i < KEY_SLOTS; i++) begin
        if (insert_i && !hit_o && free_oh[i]) slot_key_q[i] <= key_i;
      end
    end
  end

  always_comb begin
    held_count_o = '0;
    for (int i = 0; i < KEY_SLOTS; i++) begin
      held_count_o = held_count_o + {3'b000, slot_vld_q[i]};
    end
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// Pops scan-code bytes from the PS/2 receive FIFO, decodes set-2 prefixes,
// filters typematic repeats and tracks held keys and press count.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int KEY_SLOTS     = 4,
  parameter int CNT_W         = 8,
  parameter bit REPORT_REPEAT = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             fifo_ready,
  input  logic [7:0]       fifo_data,
  input  logic             fifo_ovf,
  output logic             nextdata_n,
  output logic             key_valid,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_make,
  output logic             key_repeat,
  output logic [7:0]       last_code,
  output logic             any_held,
  output logic [3:0]       held_count,
  output logic [CNT_W-1:0] press_count,
  output logic [1:0]       err_sticky,
  output logic [1:0]       dbg_state
);

  // Handshake: a pop is issued when fifo_ready=1 and nextdata_n is high. The
  // pop drives nextdata_n low for one cycle; the following cycle never pops
  // because the FIFO head only advances after seeing that strobe.
  logic       nextdata_n_q;
  logic       byte_vld_q;
  logic [7:0] byte_q;
  logic       pop;

  prefix_state_e state_q, state_d;
  logic [2:0]    skip_q, skip_d;

  logic             key_valid_q, key_ext_q, key_make_q, key_repeat_q;
  logic [7:0]       key_code_q, last_code_q;
  logic [CNT_W-1:0] press_count_q;
  logic [1:0]       err_q;

  logic ev, ev_ext, ev_make, ev_pause;
  logic slot_hit, slot_full, slot_insert, slot_delete;
  logic repeat_ev, new_make, emit;
  logic [3:0] slot_count;

  assign pop = fifo_ready && nextdata_n_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      nextdata_n_q <= 1'b1;
      byte_vld_q   <= 1'b0;
      byte_q       <= '0;
    end else begin
      nextdata_n_q <= !pop;
      byte_vld_q   <= pop;
      if (pop) byte_q <= fifo_data;
    end
  end

  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    ev       = 1'b0;
    ev_ext   = 1'b0;
    ev_make  = 1'b0;
    ev_pause = 1'b0;
    if (byte_vld_q) begin
      if (skip_q != 3'd0) begin
        skip_d = skip_q - 3'd1;
      end else if (byte_q == SC_E0) begin
        state_d = P_E0;
      end else if (byte_q == SC_F0) begin
        state_d = (state_q == P_E0 || state_q == P_E0F0) ? P_E0F0 : P_F0;
      end else if (state_q == P_IDLE && is_ignored(byte_q)) begin
        state_d = P_IDLE;
      end else if (state_q == P_IDLE && byte_q == SC_E1) begin
        ev       = 1'b1;
        ev_make  = 1'b1;
        ev_pause = 1'b1;
        skip_d   = PAUSE_SKIP;
      end else begin
        ev      = 1'b1;
        ev_ext  = (state_q == P_E0) || (state_q == P_E0F0);
        ev_make = (state_q == P_IDLE) || (state_q == P_E0);
        state_d = P_IDLE;
      end
    end
  end

  // Pause is reported as a make but never occupies a slot.
  assign slot_insert = ev && ev_make && !ev_pause;
  assign slot_delete = ev && !ev_make;
  assign repeat_ev   = slot_insert && slot_hit;
  assign new_make    = ev && ev_make && !repeat_ev;
  assign emit        = ev && (!repeat_ev || REPORT_REPEAT);

  ps2_key_slots #(
    .KEY_SLOTS(KEY_SLOTS)
  ) u_slots (
    .clock       (clock),
    .reset       (reset),
    .key_i       ({ev_ext, byte_q}),
    .insert_i    (slot_insert),
    .delete_i    (slot_delete),
    .hit_o       (slot_hit),
    .full_o      (slot_full),
    .held_count_o(slot_count)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= P_IDLE;
      skip_q        <= '0;
      key_valid_q   <= 1'b0;
      key_code_q    <= '0;
      key_ext_q     <= 1'b0;
      key_make_q    <= 1'b0;
      key_repeat_q  <= 1'b0;
      last_code_q   <= '0;
      press_count_q <= '0;
      err_q         <= '0;
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      key_valid_q <= emit;
      if (emit) begin
        key_code_q   <= byte_q;
        key_ext_q    <= ev_ext;
        key_make_q   <= ev_make;
        key_repeat_q <= repeat_ev;
      end
      if (new_make) begin
        press_count_q <= press_count_q + CNT_W'(1);
        last_code_q   <= byte_q;
      end
      if (slot_insert && !slot_hit && slot_full) err_q[0] <= 1'b1;
      if (fifo_ovf) err_q[1] <= 1'b1;
    end
  end

  // Slot flops update on the same edge as key_valid, so the count already
  // reflects the event being reported.
  assign held_count  = slot_count;
  assign any_held    = (slot_count != 4'd0);
  assign nextdata_n  = nextdata_n_q;
  assign key_valid   = key_valid_q;
  assign key_code    = key_code_q;
  assign key_ext     = key_ext_q;
  assign key_make    = key_make_q;
  assign key_repeat  = key_repeat_q;
  assign last_code   = last_code_q;
  assign press_count = press_count_q;
  assign err_sticky  = err_q;
  assign dbg_state   = state_q;

endmodule
